// File: rtl/regfile_pkg.sv
// Shared FSM encoding and parameter defaults for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;

endpackage

// File: rtl/regfile_bank.sv
// One write / one read distributed-RAM bank; write on the clock edge, read combinational.
// No handshake: the write port is always accepted and the read is a pure lookup.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  // No reset on the array; contents are zeroed by the owner's clear sweep.
  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/regfile_multiport.sv
// Register file with NRD registered read ports (1-cycle latency, write-first bypass), one write port.
// ready stays low for NREGS cycles after reset while a sweep zeroes every entry; requests are ignored then.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_id,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_valid,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_id,
  input  logic [XLEN-1:0]     wr_data,
  output logic                ready
);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   clr_idx;
  logic            clr_last;
  logic            run;
  logic            wr_to_zero;
  logic            bank_we;
  logic [AW-1:0]   bank_waddr;
  logic [XLEN-1:0] bank_wdata;

  assign clr_last   = (clr_idx == AW'(NREGS - 1));
  assign run        = (state == RUN);
  assign wr_to_zero = (ZERO_REG != 0) && (wr_id == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // The sweep owns the shared write port while clearing; user writes take over in RUN.
  always_comb begin
    ready      = run;
    bank_we    = 1'b0;
    bank_waddr = wr_id;
    bank_wdata = wr_data;
    if (!rst) begin
      case (state)
        CLEAR: begin
          bank_we    = 1'b1;
          bank_waddr = clr_idx;
          bank_wdata = '0;
        end
        RUN:     bank_we = wr_en && !wr_to_zero;
        default: bank_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + AW'(1);
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0]   id;
    logic [XLEN-1:0] bank_rdata;
    logic            hit_zero;
    logic            hit_wr;
    logic [XLEN-1:0] data_nxt;
    logic [XLEN-1:0] data_q;
    logic            valid_q;

    assign id = rd_id[p*AW +: AW];

    regfile_bank #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .raddr (id),
      .rdata (bank_rdata)
    );

    // Register 0 short-circuits ahead of the bypass so a discarded write never leaks out.
    assign hit_zero = (ZERO_REG != 0) && (id == '0);
    assign hit_wr   = wr_en && (wr_id == id);

    always_comb begin
      data_nxt = bank_rdata;
      if (hit_zero) begin
        data_nxt = '0;
      end else if (hit_wr) begin
        data_nxt = wr_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= run && rd_en[p];
        if (run && rd_en[p]) begin
          data_q <= data_nxt;
        end
      end
    end

    assign rd_data[p*XLEN +: XLEN] = data_q;
    assign rd_valid[p]             = valid_q;
  end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count; power of two, at least 2.
REQ-003 SHALL have parameter NRD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when set to 1.
REQ-005 SHALL have derived localparam AW = $clog2(NREGS).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port rd_en, input, NRD bits: per-port read request.
REQ-009 SHALL have port rd_id, input, NRD*AW bits: per-port read index; port p occupies slice [p*AW +: AW].
REQ-010 SHALL have port rd_data, output, NRD*XLEN bits: per-port registered read data; port p occupies slice [p*XLEN +: XLEN].
REQ-011 SHALL have port rd_valid, output, NRD bits: per-port strobe, high when rd_data was updated this cycle.
REQ-012 SHALL have port wr_en, input, 1 bit: write request.
REQ-013 SHALL have port wr_id, input, AW bits: write index.
REQ-014 SHALL have port wr_data, input, XLEN bits: write data.
REQ-015 SHALL have port ready, output, 1 bit: high when the file accepts reads and writes.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-017 In CLEAR: one register zeroed per cycle, indexed by clr_idx counting 0..NREGS-1; ready=0; rd_en and wr_en ignored.
REQ-018 CLEAR SHALL transition to RUN on the cycle clr_idx==NREGS-1 is written; ready rises the next cycle, exactly NREGS cycles after rst deasserts.
REQ-019 In RUN: when rd_en[p]=1, rd_data[p] SHALL load the content of rd_id[p] at the next edge, rd_valid[p]=1 for that cycle only (1-cycle latency).
REQ-020 In RUN with rd_en[p]=0, rd_data[p] SHALL hold its value and rd_valid[p] SHALL be 0.
REQ-021 In RUN with wr_en=1, wr_data SHALL be stored at wr_id on the rising edge.
REQ-022 Read and write in the same cycle SHALL both take effect (no read/write priority).
REQ-023 Same-cycle write bypass: if wr_en=1 and rd_en[p]=1 and rd_id[p]==wr_id, rd_data[p] SHALL receive wr_data (write-first).
REQ-024 With ZERO_REG=1: writes to index 0 SHALL be discarded, reads of index 0 SHALL return 0, and the bypass SHALL NOT apply to index 0.
REQ-025 All NRD ports SHALL be independent; any ports may read the same index in the same cycle.
REQ-026 Out-of-range indices cannot occur (NREGS is a power of two); no range checks.

Reset
REQ-027 rst=1 SHALL force state=CLEAR, clr_idx=0, ready=0, rd_data=0, rd_valid=0 at the next edge.
REQ-028 rst asserted mid-CLEAR or mid-RUN SHALL restart the full clear sweep; contents written before rst are lost.
REQ-029 Storage SHALL NOT use a reset net; zeroing is done only by the CLEAR sweep.

Structure
REQ-030 Package regfile_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the parameter defaults XLEN, NREGS and NRD.
REQ-031 Sub-module regfile_bank SHALL be a 1-write/1-read distributed-RAM bank of NREGS x XLEN, instantiated NRD times; all instances share the write port.
REQ-032 The FSM, clear counter, bypass logic and zero-register logic SHALL reside in the top-level module.

Verification
REQ-033 rst pulsed 1 cycle, NREGS=32 -> ready=0 for 32 cycles then 1; every index read on both ports returns 0.
REQ-034 write r5=0xDEADBEEF, next cycle read r5 on port0 and port1 -> both rd_data=0xDEADBEEF, rd_valid=2'b11.
REQ-035 Same cycle: write r7=0x12345678 and read r7 on port0 -> port0 rd_data=0x12345678 (bypass).
REQ-036 write r0=0xFFFFFFFF with ZERO_REG=1, then read r0 with bypass in the same cycle -> rd_data=0; with ZERO_REG=0 -> 0xFFFFFFFF.
REQ-037 write r3=0xA5, rst mid-RUN, wait for ready, read r3 -> 0; reads issued during CLEAR give rd_valid=0.
REQ-038 Random reads and writes over 10k cycles with NRD=3 and XLEN=16 compared against a reference model -> zero mismatches.
